// File: rtl/stv_util_pkg.sv
// -----------------------------------------------------------------------------
// stv_util_pkg
//
// Shared helpers for the stv return-path blocks.
//   idx_width(n)       : number of bits needed to index n items, minimum 1.
//   onehot_to_idx(vec) : binary index of the lowest set bit of vec, or 0 when
//                        vec is all zero. vec is a fixed-width container;
//                        callers zero-extend narrower vectors into it.
// -----------------------------------------------------------------------------
package stv_util_pkg;

    // Widest one-hot vector onehot_to_idx can encode.
    localparam int unsigned STV_MAX_ONEHOT_W = 256;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Scan from the top down so the last hit (the lowest set bit) wins.
    function automatic int unsigned onehot_to_idx(input logic [STV_MAX_ONEHOT_W-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = STV_MAX_ONEHOT_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/stv_sync_fifo.sv
// -----------------------------------------------------------------------------
// stv_sync_fifo
//
// Single-clock FIFO with registered pointers and occupancy count. Any DEPTH
// >= 1 is supported; pointers wrap explicitly at DEPTH-1 -> 0. The read data is
// the current head (show-ahead), with no write-to-read bypass: an entry pushed
// this cycle is visible at the head from the next cycle.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset (clears pointers and count)
//   push_i   in   write wdata_i at the tail; ignored when full unless a pop
//                 happens in the same cycle
//   wdata_i  in   [WIDTH] write data
//   pop_i    in   advance the head; ignored when empty
//   rdata_o  out  [WIDTH] head entry (valid only when !empty_o)
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
//   count_o  out  [$clog2(DEPTH+1)] current occupancy
// -----------------------------------------------------------------------------
module stv_sync_fifo
    import stv_util_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only safe when the head slot is freed in the
    // same cycle; when full, tail and head point at the same slot.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/stv_response_router.sv
// -----------------------------------------------------------------------------
// stv_response_router
//
// Return path for the priority arbiter. Every accepted grant records the
// winner's index in an in-order tracking FIFO; each response from the single
// shared responder is steered to the requester at the FIFO head. Responses
// come back strictly in grant order (in-order responders only).
//
// Handshakes: a transfer happens on a side when valid and ready are both high
// at a rising edge. valid must not depend on ready on the same side. Here the
// shared rsp_ready_o is a combinational copy of the head owner's rsp_ready_i,
// and rsp_valid_o is a combinational copy of rsp_valid_i on the owner's bit.
//
// Parameters: INPUTS (requesters, <= 256), DEPTH (max outstanding), DATA_W.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset; discards tracked entries
//   gnt          in   [INPUTS] one-hot grant for the current request
//   gnt_fire     in   request accepted downstream this cycle
//   cmd_ready    out  tracker can take a grant; the arbiter must gate on it
//   rsp_valid_i  in   shared response valid
//   rsp_ready_o  out  shared response ready
//   rsp_data_i   in   [DATA_W] shared response payload
//   rsp_valid_o  out  [INPUTS] per-requester response valid
//   rsp_ready_i  in   [INPUTS] per-requester response ready
//   rsp_data_o   out  [DATA_W] payload broadcast to all requesters
//   outstanding  out  [$clog2(DEPTH+1)] tracked transactions
//
// Build options:
//   STV_RSP_ROUTER_FULL_BYPASS_EN  cmd_ready = ~full | pop, letting a full
//                                  tracker accept a grant in a pop cycle.
//                                  Creates a combinational path from
//                                  rsp_valid_i/rsp_ready_i to cmd_ready.
//   STV_ASSERT_ON                  enables the protocol assertions.
// -----------------------------------------------------------------------------
module stv_response_router
    import stv_util_pkg::*;
#(
    parameter int INPUTS = 8,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INPUTS-1:0]          gnt,
    input  logic                       gnt_fire,
    output logic                       cmd_ready,
    input  logic                       rsp_valid_i,
    output logic                       rsp_ready_o,
    input  logic [DATA_W-1:0]          rsp_data_i,
    output logic [INPUTS-1:0]          rsp_valid_o,
    input  logic [INPUTS-1:0]          rsp_ready_i,
    output logic [DATA_W-1:0]          rsp_data_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding
);

    localparam int IDX_W = idx_width(INPUTS);

    logic [STV_MAX_ONEHOT_W-1:0] gnt_ext;
    logic [IDX_W-1:0]            push_idx;
    logic [IDX_W-1:0]            head_idx;
    logic                        fifo_push;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        rsp_pop;

    // Encode the winner. A zero grant encodes to 0 but is never pushed.
    always_comb begin
        gnt_ext              = '0;
        gnt_ext[INPUTS-1:0]  = gnt;
    end

    assign push_idx  = IDX_W'(onehot_to_idx(gnt_ext));
    assign fifo_push = gnt_fire & cmd_ready & (|gnt);

    // Head steering. While empty nothing is ready, so a stray response stalls
    // rather than being consumed.
    always_comb begin
        rsp_valid_o = '0;
        rsp_ready_o = 1'b0;
        if (!fifo_empty) begin
            rsp_valid_o[head_idx] = rsp_valid_i;
            rsp_ready_o           = rsp_ready_i[head_idx];
        end
    end

    assign rsp_pop    = rsp_valid_i & rsp_ready_o;
    assign rsp_data_o = rsp_data_i;

`ifdef STV_RSP_ROUTER_FULL_BYPASS_EN
    assign cmd_ready = ~fifo_full | rsp_pop;
`else
    assign cmd_ready = ~fifo_full;
`endif

    stv_sync_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (DEPTH)
    ) u_track_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (push_idx),
        .pop_i   (rsp_pop),
        .rdata_o (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding)
    );

`ifdef STV_ASSERT_ON
    if (INPUTS < 1 || DEPTH < 1) begin : g_bad_params
        $error("stv_response_router: INPUTS and DEPTH must be >= 1");
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_fire |-> $onehot(gnt));

    a_no_rsp_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid_i |-> !fifo_empty);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_push |-> (!fifo_full || rsp_pop));
`endif

endmodule

// File: tb/tb_stv_response_router.sv
module tb_stv_response_router;

    logic        clk;
    logic        rst_n;

    // DUT with DEPTH=4
    logic [7:0]  gnt;
    logic        gnt_fire;
    logic        cmd_ready;
    logic        rsp_valid_i;
    logic        rsp_ready_o;
    logic [31:0] rsp_data_i;
    logic [7:0]  rsp_valid_o;
    logic [7:0]  rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [2:0]  outstanding;

    // DUT with DEPTH=3 for non-power-of-2 wrap
    logic [7:0]  gnt3;
    logic        gnt_fire3;
    logic        cmd_ready3;
    logic        rsp_valid_i3;
    logic        rsp_ready_o3;
    logic [31:0] rsp_data_i3;
    logic [7:0]  rsp_valid_o3;
    logic [7:0]  rsp_ready_i3;
    logic [31:0] rsp_data_o3;
    logic [1:0]  outstanding3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] dexp_q[$];
    logic [7:0]  exp3_q[$];
    logic [31:0] dexp3_q[$];

    stv_response_router #(.INPUTS(8), .DEPTH(4), .DATA_W(32)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gnt         (gnt),
        .gnt_fire    (gnt_fire),
        .cmd_ready   (cmd_ready),
        .rsp_valid_i (rsp_valid_i),
        .rsp_ready_o (rsp_ready_o),
        .rsp_data_i  (rsp_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .outstanding (outstanding)
    );

    stv_response_router #(.INPUTS(8), .DEPTH(3), .DATA_W(32)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .gnt         (gnt3),
        .gnt_fire    (gnt_fire3),
        .cmd_ready   (cmd_ready3),
        .rsp_valid_i (rsp_valid_i3),
        .rsp_ready_o (rsp_ready_o3),
        .rsp_data_i  (rsp_data_i3),
        .rsp_valid_o (rsp_valid_o3),
        .rsp_ready_i (rsp_ready_i3),
        .rsp_data_o  (rsp_data_o3),
        .outstanding (outstanding3)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one grant on the DEPTH=4 DUT; the bench decides acceptance from
    // its own occupancy model (expected queue length).
    task automatic grant(input logic [7:0] g);
        logic [7:0] low;
        low      = g & (~g + 8'd1);
        gnt      = g;
        gnt_fire = 1'b1;
        if (g != 8'h00 && exp_q.size() < 4) exp_q.push_back(low);
        tick();
        gnt_fire = 1'b0;
        gnt      = 8'h00;
    endtask

    task automatic drive_rsp(input logic [31:0] d);
        bit done;
        done        = 1'b0;
        rsp_valid_i = 1'b1;
        rsp_data_i  = d;
        dexp_q.push_back(d);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (rsp_ready_o) done = 1'b1;
        end
        check("rsp_handshake", {31'd0, done}, 32'd1);
        tick();
        rsp_valid_i = 1'b0;
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (rst_n && rsp_valid_i && rsp_ready_o) begin
            if (exp_q.size() == 0 || dexp_q.size() == 0) begin
                check("unexpected_rsp", {24'd0, rsp_valid_o}, 32'd0);
            end else begin
                logic [7:0]  eo;
                logic [31:0] ed;
                eo = exp_q.pop_front();
                ed = dexp_q.pop_front();
                check("rsp_owner", {24'd0, rsp_valid_o}, {24'd0, eo});
                check("rsp_data", rsp_data_o, ed);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid_i3 && rsp_ready_o3) begin
            if (exp3_q.size() == 0 || dexp3_q.size() == 0) begin
                check("unexpected_rsp3", {24'd0, rsp_valid_o3}, 32'd0);
            end else begin
                logic [7:0]  eo;
                logic [31:0] ed;
                eo = exp3_q.pop_front();
                ed = dexp3_q.pop_front();
                check("rsp3_owner", {24'd0, rsp_valid_o3}, {24'd0, eo});
                check("rsp3_data", rsp_data_o3, ed);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        gnt          = 8'h00;
        gnt_fire     = 1'b0;
        rsp_valid_i  = 1'b0;
        rsp_data_i   = 32'd0;
        rsp_ready_i  = 8'h00;
        gnt3         = 8'h00;
        gnt_fire3    = 1'b0;
        rsp_valid_i3 = 1'b0;
        rsp_data_i3  = 32'd0;
        rsp_ready_i3 = 8'hFF;

        // Reset for two cycles
        tick();
        tick();
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_outstanding", {29'd0, outstanding}, 32'd0);
        check("rst_rsp_valid_o", {24'd0, rsp_valid_o}, 32'd0);
        check("rst_rsp_ready_o", {31'd0, rsp_ready_o}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Response while empty is stalled
        rsp_valid_i = 1'b1;
        rsp_ready_i = 8'hFF;
        rsp_data_i  = 32'hDEAD;
        @(negedge clk);
        check("empty_rsp_ready_o", {31'd0, rsp_ready_o}, 32'd0);
        check("empty_rsp_valid_o", {24'd0, rsp_valid_o}, 32'd0);
        tick();
        @(negedge clk);
        check("empty_stall_ready_o", {31'd0, rsp_ready_o}, 32'd0);
        tick();
        rsp_valid_i = 1'b0;

        // Zero grant: no push
        grant(8'h00);
        @(negedge clk);
        check("zero_gnt_outstanding", {29'd0, outstanding}, 32'd0);
        tick();

        // In-order return
        grant(8'h04);
        grant(8'h80);
        grant(8'h01);
        @(negedge clk);
        check("inorder_outstanding3", {29'd0, outstanding}, 32'd3);
        tick();
        drive_rsp(32'hA);
        @(negedge clk);
        check("inorder_outstanding2", {29'd0, outstanding}, 32'd2);
        tick();
        drive_rsp(32'hB);
        drive_rsp(32'hC);
        @(negedge clk);
        check("inorder_outstanding0", {29'd0, outstanding}, 32'd0);
        tick();

        // Back-pressure on head owner 5
        grant(8'h20);
        rsp_ready_i = 8'hDF;
        rsp_valid_i = 1'b1;
        rsp_data_i  = 32'h55;
        dexp_q.push_back(32'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_rsp_ready_o", {31'd0, rsp_ready_o}, 32'd0);
            check("bp_rsp_valid_o", {24'd0, rsp_valid_o}, 32'h20);
            check("bp_outstanding", {29'd0, outstanding}, 32'd1);
            tick();
        end
        rsp_ready_i = 8'hFF;
        @(negedge clk);
        check("bp_release_ready_o", {31'd0, rsp_ready_o}, 32'd1);
        tick();
        rsp_valid_i = 1'b0;
        @(negedge clk);
        check("bp_outstanding_after", {29'd0, outstanding}, 32'd0);
        tick();

        // Full
        grant(8'h01);
        grant(8'h02);
        grant(8'h04);
        grant(8'h08);
        @(negedge clk);
        check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("full_outstanding", {29'd0, outstanding}, 32'd4);
        tick();
        grant(8'h10);
        @(negedge clk);
        check("full_ignored_outstanding", {29'd0, outstanding}, 32'd4);
        tick();
        rsp_valid_i = 1'b1;
        rsp_data_i  = 32'h1;
        dexp_q.push_back(32'h1);
        @(negedge clk);
`ifdef STV_RSP_ROUTER_FULL_BYPASS_EN
        check("full_pop_cmd_ready", {31'd0, cmd_ready}, 32'd1);
`else
        check("full_pop_cmd_ready", {31'd0, cmd_ready}, 32'd0);
`endif
        tick();
        rsp_valid_i = 1'b0;
        @(negedge clk);
        check("after_pop_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("after_pop_outstanding", {29'd0, outstanding}, 32'd3);
        tick();
        drive_rsp(32'h2);
        drive_rsp(32'h3);
        drive_rsp(32'h4);
        @(negedge clk);
        check("drain_outstanding", {29'd0, outstanding}, 32'd0);
        tick();

        // Mid-operation reset
        grant(8'h02);
        grant(8'h40);
        @(negedge clk);
        check("midrst_outstanding_before", {29'd0, outstanding}, 32'd2);
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_outstanding", {29'd0, outstanding}, 32'd0);
        check("midrst_rsp_ready_o", {31'd0, rsp_ready_o}, 32'd0);
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        grant(8'h08);
        drive_rsp(32'h77);

        // Wrap with DEPTH=3: push and pop together at occupancy 1
        gnt3      = 8'h01;
        gnt_fire3 = 1'b1;
        exp3_q.push_back(8'h01);
        tick();
        for (int k = 0; k < 10; k++) begin
            logic [7:0] nxt;
            nxt          = 8'h01 << ((k + 1) % 8);
            gnt3         = nxt;
            gnt_fire3    = 1'b1;
            exp3_q.push_back(nxt);
            rsp_valid_i3 = 1'b1;
            rsp_data_i3  = 32'h100 + k;
            dexp3_q.push_back(32'h100 + k);
            @(negedge clk);
            check("wrap_outstanding", {30'd0, outstanding3}, 32'd1);
            check("wrap_rsp_ready_o", {31'd0, rsp_ready_o3}, 32'd1);
            tick();
        end
        gnt_fire3   = 1'b0;
        gnt3        = 8'h00;
        rsp_data_i3 = 32'h1FF;
        dexp3_q.push_back(32'h1FF);
        @(negedge clk);
        check("wrap_last_ready_o", {31'd0, rsp_ready_o3}, 32'd1);
        tick();
        rsp_valid_i3 = 1'b0;
        @(negedge clk);
        check("wrap_outstanding_end", {30'd0, outstanding3}, 32'd0);
        tick();

        // Every expected response must have been observed
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("exp3_q_empty", exp3_q.size(), 32'd0);
        check("dexp_q_empty", dexp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
